// File: rtl/imem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: NOP encoding,
// loader state encoding and the index-width helper.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    // Number of word-index bits needed to address a store of 'depth' words.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_loadable_ram.sv
// Instruction storage: DEPTH x DATA_W, one synchronous write port and one
// synchronous read port. The read register holds its value when re=0,
// which is what lets the fetch port hold during a stall.
module imem_ram
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port: one word per cycle, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered read, holds the last word when not enabled.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Word-addressed instruction memory with a 1-cycle registered fetch port,
// stall hold, out-of-range fault flag and a streaming boot-loader port.
// Fetch is blocked whenever the loader can write, so reads and writes never
// collide in the storage array.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 256,
    parameter int ADDR_W        = 32,
    parameter bit CLEAR_ON_LOAD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    input  logic                     fetch_stall,
    output logic [DATA_W-1:0]        fetch_instr,
    output logic                     fetch_valid,
    output logic                     fetch_fault,
    input  logic                     ld_start,
    input  logic [$clog2(DEPTH)-1:0] ld_base,
    input  logic [$clog2(DEPTH):0]   ld_count,
    input  logic                     ld_valid,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    output logic                     ld_busy,
    output logic                     ld_done,
    output logic                     ld_err
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [IDX_W+1:0] DEPTH_EXT = (IDX_W+2)'(DEPTH);
    localparam logic [IDX_W-1:0] CLR_LAST  = IDX_W'(DEPTH - 1);

    ld_state_e          state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     rem_q, rem_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               ld_err_q, ld_err_d;
    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic               sel_q, sel_d;

    logic [IDX_W+1:0]   ld_end_s;
    logic               ld_bad_s;
    logic               addr_fault_s;
    logic               rd_en_s;
    logic               wr_en_s;
    logic [IDX_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]  wr_data_s;
    logic [DATA_W-1:0]  rd_data_s;

    assign addr_fault_s = |fetch_addr[ADDR_W-1:IDX_W];

    // Load range check, widened so base+count cannot overflow.
    always_comb begin
        ld_end_s = {2'b00, ld_base} + {1'b0, ld_count};
        ld_bad_s = (ld_count == {(IDX_W+1){1'b0}}) || (ld_end_s > DEPTH_EXT);
    end

    // Loader FSM next-state, pointer/remaining/clear counters and error pulse.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        clr_cnt_d = clr_cnt_q;
        ld_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    if (ld_bad_s) begin
                        ld_err_d = 1'b1;
                    end else begin
                        ptr_d     = ld_base;
                        rem_d     = ld_count;
                        clr_cnt_d = {IDX_W{1'b0}};
                        state_d   = CLEAR_ON_LOAD ? ST_CLEAR : ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = {IDX_W{1'b0}};
                    state_d   = ST_LOAD;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    ptr_d = ptr_q + IDX_W'(1);
                    rem_d = rem_q - (IDX_W+1)'(1);
                    if (rem_q == (IDX_W+1)'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage write port: zero fill during CLEAR, streamed words during LOAD.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = ptr_q;
        wr_data_s = ld_data;
        if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_cnt_q;
            wr_data_s = DATA_W'(NOP_INSTR);
        end else if (state_q == ST_LOAD) begin
            wr_en_s = ld_valid;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Fetch next-state: hold on stall, blank when blocked/idle, flag faults.
    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        sel_d   = sel_q;
        rd_en_s = 1'b0;
        if (fetch_stall) begin
            valid_d = valid_q;
        end else if ((state_q != ST_IDLE) || !fetch_req) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
            sel_d   = 1'b0;
        end else if (addr_fault_s) begin
            valid_d = 1'b1;
            fault_d = 1'b1;
            sel_d   = 1'b0;
        end else begin
            valid_d = 1'b1;
            fault_d = 1'b0;
            sel_d   = 1'b1;
            rd_en_s = 1'b1;
        end
    end

    // State and output registers; array contents are outside this reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= {IDX_W{1'b0}};
            rem_q     <= {(IDX_W+1){1'b0}};
            clr_cnt_q <= {IDX_W{1'b0}};
            ld_err_q  <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            clr_cnt_q <= clr_cnt_d;
            ld_err_q  <= ld_err_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            sel_q     <= sel_d;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en_s),
        .waddr_i (wr_addr_s),
        .wdata_i (wr_data_s),
        .re_i    (rd_en_s),
        .raddr_i (fetch_addr[IDX_W-1:0]),
        .rdata_o (rd_data_s)
    );

    // The read register is the data stage; sel_q gates it to NOP otherwise.
    assign fetch_instr = sel_q ? rd_data_s : DATA_W'(NOP_INSTR);
    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign ld_ready    = (state_q == ST_LOAD);
    assign ld_busy     = (state_q != ST_IDLE);
    assign ld_done     = (state_q == ST_DONE);
    assign ld_err      = ld_err_q;

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed-ROM instruction memory: word-addressed instruction store with a 1-cycle registered fetch port, stall hold and out-of-range fault flag.
- Adds a streaming boot-loader port, so programs (e.g. the median-stencil image) are written at run time instead of being hard-coded.
- Sits between the PC/IF stage and the IF/ID register.
- The loader is driven by the testbench or a host shim while the core is held.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 256, number of instruction words (power of two, >=4).
- ADDR_W, 32, fetch address width; word-addressed (address n selects word n).
- CLEAR_ON_LOAD, 1, 1 = zero the whole array before each load; 0 = overwrite only the loaded range.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_W  word address.
- fetch_stall  in  1  hold fetch outputs (pipeline stall).
- fetch_instr  out  DATA_W  instruction; NOP (all zeros) when not valid.
- fetch_valid  out  1  fetch_instr is valid.
- fetch_fault  out  1  address was out of range; qualifies fetch_valid.
- ld_start  in  1  begin a load; samples ld_base and ld_count.
- ld_base  in  $clog2(DEPTH)  first word index to write.
- ld_count  in  $clog2(DEPTH)+1  number of words to write.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  DATA_W  instruction word.
- ld_ready  out  1  loader accepts a word this cycle.
- ld_busy  out  1  loader active; fetch is blocked.
- ld_done  out  1  one-cycle pulse when the load completes.
- ld_err  out  1  one-cycle pulse when ld_start carries a bad range.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; fetch_instr=0. Array contents are not reset.
- IDX_W=$clog2(DEPTH); idx=fetch_addr[IDX_W-1:0].
- Fault condition: fetch_addr[ADDR_W-1:IDX_W] != 0.
- Fetch has 1-cycle latency, evaluated at a clock edge:
  - fetch_stall=1: all fetch outputs hold, even while ld_busy.
  - else if state!=IDLE or fetch_req=0: valid=0, fault=0, instr=0.
  - else if fault condition: valid=1, fault=1, instr=0.
  - else: valid=1, fault=0, instr=mem[idx].
- Loader FSM states: IDLE, CLEAR, LOAD, DONE.
  - IDLE: on ld_start, error if ld_count==0 or ld_base+ld_count>DEPTH (compute in IDX_W+2 bits). On error, ld_err=1 for the next cycle and stay in IDLE. Otherwise latch ptr=ld_base and rem=ld_count, then go to CLEAR if CLEAR_ON_LOAD, else LOAD.
  - CLEAR: write 0 to word clr_cnt, clr_cnt 0..DEPTH-1, one word per cycle. Exactly DEPTH cycles, then LOAD.
  - LOAD: ld_ready=1. On ld_valid&ld_ready, mem[ptr]=ld_data, ptr++, rem--. When the word with rem==1 is accepted, go to DONE. ld_valid=0 inserts bubbles with no timeout.
  - DONE: ld_done=1 for exactly one cycle, then IDLE.
- ld_busy=1 in CLEAR, LOAD and DONE; ld_ready=1 only in LOAD.
- ld_start outside IDLE is ignored; no ld_err is raised.
- ld_start and fetch_req in the same IDLE cycle: the fetch is served (read of old contents), and the FSM leaves IDLE on the same edge.
- No read/write collision exists by construction: fetch is blocked whenever any write can occur.
- Reset mid-load: FSM returns to IDLE. A partial image remains in the array. Software must reload.
- ptr never wraps: range is checked at start.

Decomposition:
- Shared package imem_pkg:
  - NOP_INSTR (32'b0).
  - Loader state enum {IDLE, CLEAR, LOAD, DONE}.
  - Function for IDX_W.
- One sub-module, imem_ram: DEPTH x DATA_W, 1 sync write port and 1 sync read port, no reset.
- The top level holds the FSM, counters, range check and fetch output registers.

Test Plan:
- Reset, then load base=0 count=4 with words 0x0000000F, 0x00000007, 0x00000005, 0x0000000A, CLEAR_ON_LOAD=1 → ld_busy high for 256 cycles in CLEAR, then 4 accepted words. ld_done pulses once. Fetch addr 2 → next cycle instr=0x00000005, valid=1. Fetch addr 10 → instr=0.
- Load with ld_valid toggling every other cycle, base=100 count=3 → exactly 3 writes to 100..102. Fetch addr 101 returns the 2nd word.
- ld_start with base=250 count=7 → ld_err pulse, ld_busy stays 0. ld_start with count=0 → ld_err pulse.
- Fetch addr 0x00000100 (DEPTH=256) → valid=1, fault=1, instr=0.
- fetch_stall held 3 cycles after a valid fetch of addr 2 → instr/valid unchanged while fetch_addr changes. Release → new address served 1 cycle later.
- Assert rst_n=0 mid-LOAD after 2 of 4 words → outputs 0 immediately. After release, state IDLE and fetch works. Words 0..1 new, words 2..3 zero (cleared).
